cache_controller: RTL and testbench
===================================

CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and reset, both sampled on rising clk.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- cpu_addr  in  10  word address from execute/memory stage
- cpu_wdata  in  10  store data
- cpu_read  in  1  load request
- cpu_write  in  1  store request
- cpu_rdata  out  10  load data, combinational from the array on a hit
- cache_Ready  out  1  high = request complete or no request; low = pipeline registers hold
- mem_addr  out  10  backing RAM address
- mem_wdata  out  10  backing RAM write data
- mem_read  out  1  RAM read strobe, held until mem_ready
- mem_write  out  1  RAM write strobe, held until mem_ready
- mem_rdata  in  10  RAM read data, valid with mem_ready
- mem_ready  in  1  RAM completion, single-cycle pulse

Function
REQ-003 The cache SHALL be direct-mapped and write-back/write-allocate, with 8 lines of one 10-bit word each: index = cpu_addr[2:0], tag = cpu_addr[9:3].
REQ-004 Each line SHALL hold valid, dirty, a 7-bit tag and 10-bit data.
REQ-005 The FSM SHALL have three states: COMPARE, WRITEBACK, ALLOCATE.
REQ-006 In COMPARE, a hit is (cpu_read|cpu_write) & valid[idx] & tag match.
REQ-007 In COMPARE with a hit or no request, cache_Ready SHALL be 1 combinationally in the same cycle.
REQ-008 A read hit SHALL drive cpu_rdata = data[idx] in the same cycle (zero wait states).
REQ-009 A write hit SHALL write cpu_wdata into data[idx] and set dirty[idx] on the next rising edge.
REQ-010 On a miss, cache_Ready SHALL be 0. Next state SHALL be WRITEBACK if valid[idx]&dirty[idx], otherwise ALLOCATE.
REQ-011 In WRITEBACK:
- outputs: mem_write=1, mem_addr={tag[idx],idx}, mem_wdata=data[idx], cache_Ready=0
- on mem_ready: clear dirty[idx], go to ALLOCATE
REQ-012 In ALLOCATE:
- outputs: mem_read=1, mem_addr=cpu_addr, cache_Ready=0
- on mem_ready: load mem_rdata, set valid, clear dirty, write tag, return to COMPARE
REQ-013 After ALLOCATE the request SHALL re-evaluate in COMPARE as a hit. Miss latency = 1 + mem wait + 1 cycles (clean victim), plus the writeback duration (dirty victim).
REQ-014 cpu_addr, cpu_wdata, cpu_read and cpu_write SHALL be stable while cache_Ready=0; the block SHALL NOT latch them.
REQ-015 If cpu_read and cpu_write are both 1, the request SHALL be treated as a write.
REQ-016 mem_read and mem_write SHALL never be 1 together, and SHALL be 0 in COMPARE.
REQ-017 A mem_ready received in COMPARE SHALL be ignored.

Reset
REQ-018 Reset SHALL set:
- state = COMPARE
- all valid and dirty bits = 0
- mem_read, mem_write = 0
- cache_Ready = 1 (when no request is present)
REQ-019 Reset asserted in WRITEBACK or ALLOCATE SHALL abort the transaction on the next edge with no array update. Dirty data is discarded.
REQ-020 Tag and data arrays SHALL NOT require reset.

Structure
REQ-021 A shared package SHALL hold:
- the state enum
- constants: ADDR_W=10, DATA_W=10, IDX_W=3, TAG_W=7, LINES=8
REQ-022 One sub-module, cache_line_array, SHALL hold the valid/dirty/tag/data storage: asynchronous read, single synchronous write port, synchronous clear of valid/dirty.

Verification
REQ-023 Cold read: after reset, cpu_read=1, addr=0x005, RAM[0x005]=0x2AA, mem_ready after 3 cycles.
- Required: cache_Ready low 5 cycles, mem_read=1 with mem_addr=0x005 until mem_ready, then cpu_rdata=0x2AA with cache_Ready=1.
REQ-024 Read hit: immediately re-read 0x005.
- Required: cache_Ready=1 and cpu_rdata=0x2AA in the same cycle, mem_read stays 0.
REQ-025 Write hit then dirty eviction:
- Stimulus: write 0x005 <= 0x155, then read 0x00D (same index, tag 1).
- Required: WRITEBACK with mem_addr=0x005, mem_wdata=0x155, then ALLOCATE with mem_addr=0x00D.
REQ-026 Write miss: write 0x3F8 <= 0x001 to a clean invalid line.
- Required: ALLOCATE of 0x3F8 only (no writeback), then the line holds 0x001 with dirty=1.
REQ-027 Reset mid-ALLOCATE: assert reset while mem_read=1.
- Required: mem_read=0 next cycle, all lines invalid, a subsequent read of the same address misses.
REQ-028 Simultaneous cpu_read=cpu_write=1 on a hit.
- Required: the array is updated with cpu_wdata and dirty is set.

Source files
------------

// File: rtl/cache_controller_pkg.sv
// Shared types and geometry for the direct-mapped, write-back cache controller.
// One word per line, so a line index is simply the low address bits.
package cache_controller_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 10;
    localparam int IDX_W  = 3;
    localparam int TAG_W  = 7;
    localparam int LINES  = 8;

    typedef enum logic [1:0] {
        COMPARE   = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    typedef struct packed {
        logic              valid;
        logic              dirty;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } line_t;

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] addr);
        return addr[IDX_W-1:0];
    endfunction

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:IDX_W];
    endfunction

endpackage

// File: rtl/cache_controller_line_array.sv
// Line storage: valid/dirty flags (clearable) plus tag/data words (never reset).
// Asynchronous read, one synchronous full-line write port.
module cache_line_array
    import cache_controller_pkg::*;
(
    input  logic             clk,
    input  logic             clear,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  line_t            wline,
    input  logic [IDX_W-1:0] ridx,
    output line_t            rline
);

    logic [LINES-1:0]  valid;
    logic [LINES-1:0]  dirty;
    logic [TAG_W-1:0]  tag  [LINES];
    logic [DATA_W-1:0] data [LINES];

    always_ff @(posedge clk) begin
        if (clear) begin
            valid <= '0;
            dirty <= '0;
        end else if (we) begin
            valid[widx] <= wline.valid;
            dirty[widx] <= wline.dirty;
        end
    end

    // Tag/data carry no reset; a clear only has to invalidate the lines.
    always_ff @(posedge clk) begin
        if (we && !clear) begin
            tag[widx]  <= wline.tag;
            data[widx] <= wline.data;
        end
    end

    always_comb begin
        rline       = '0;
        rline.valid = valid[ridx];
        rline.dirty = dirty[ridx];
        rline.tag   = tag[ridx];
        rline.data  = data[ridx];
    end

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped write-back/write-allocate cache between the CPU pipeline and a
// handshaked backing RAM. Hits complete combinationally; misses stall via cache_Ready.
module cache_controller
    import cache_controller_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_read,
    input  logic              cpu_write,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cache_Ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    state_t           state;
    line_t            line;
    line_t            wline;
    logic             we;
    logic             req;
    logic             hit;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;

    assign idx = addr_idx(cpu_addr);
    assign tag = addr_tag(cpu_addr);
    assign req = cpu_read | cpu_write;
    assign hit = req && line.valid && (line.tag == tag);

    cache_line_array u_lines (
        .clk   (clk),
        .clear (reset),
        .we    (we),
        .widx  (idx),
        .wline (wline),
        .ridx  (idx),
        .rline (line)
    );

    assign cpu_rdata   = line.data;
    assign cache_Ready = (state == COMPARE) && (!req || hit);
    assign mem_addr    = (state == WRITEBACK) ? {line.tag, idx} : cpu_addr;
    assign mem_wdata   = line.data;

    // Array update; a write beats a read when both are requested. Reset
    // suppresses any update so an aborted transaction leaves no trace.
    always_comb begin
        we    = 1'b0;
        wline = line;
        case (state)
            COMPARE: begin
                if (hit && cpu_write) begin
                    we          = 1'b1;
                    wline.data  = cpu_wdata;
                    wline.dirty = 1'b1;
                end
            end
            WRITEBACK: begin
                if (mem_ready) begin
                    we          = 1'b1;
                    wline.dirty = 1'b0;
                end
            end
            ALLOCATE: begin
                if (mem_ready) begin
                    we          = 1'b1;
                    wline.valid = 1'b1;
                    wline.dirty = 1'b0;
                    wline.tag   = tag;
                    wline.data  = mem_rdata;
                end
            end
            default: we = 1'b0;
        endcase
        if (reset)
            we = 1'b0;
    end

    // Strobes are registered alongside the state so they change only on edges
    // and can never overlap: WRITEBACK->ALLOCATE swaps them on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= COMPARE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end else begin
            case (state)
                COMPARE: begin
                    if (req && !hit) begin
                        if (line.valid && line.dirty) begin
                            state     <= WRITEBACK;
                            mem_write <= 1'b1;
                        end else begin
                            state    <= ALLOCATE;
                            mem_read <= 1'b1;
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ready) begin
                        state     <= ALLOCATE;
                        mem_write <= 1'b0;
                        mem_read  <= 1'b1;
                    end
                end
                ALLOCATE: begin
                    if (mem_ready) begin
                        state    <= COMPARE;
                        mem_read <= 1'b0;
                    end
                end
                default: begin
                    state     <= COMPARE;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Scoreboarded bench: expected RAM transactions and load data are queued when a
// request is driven and checked when the RAM model or the CPU side sees them.
module tb_cache_controller;

    typedef struct {
        bit         wr;
        logic [9:0] addr;
        logic [9:0] data;
    } txn_t;

    localparam int MEM_WAIT = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] cpu_addr;
    logic [9:0] cpu_wdata;
    logic       cpu_read;
    logic       cpu_write;
    logic [9:0] cpu_rdata;
    logic       cache_Ready;
    logic [9:0] mem_addr;
    logic [9:0] mem_wdata;
    logic       mem_read;
    logic       mem_write;
    logic [9:0] mem_rdata;
    logic       mem_ready;

    logic [9:0] ram [0:1023];
    txn_t       mq[$];
    logic [9:0] rdq[$];
    int         total = 0;
    int         bad   = 0;

    cache_controller dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_read    (cpu_read),
        .cpu_write   (cpu_write),
        .cpu_rdata   (cpu_rdata),
        .cache_Ready (cache_Ready),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // RAM model: answers after MEM_WAIT full cycles with a one-cycle mem_ready pulse.
    initial begin
        int   cnt;
        txn_t e;
        cnt       = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            chk("mem_excl", {31'd0, mem_read & mem_write}, 0);
            if (mem_read || mem_write) begin
                cnt++;
                if (cnt == 1) begin
                    chk("mem_expected", {31'd0, mq.size() > 0}, 1);
                    if (mq.size() > 0) begin
                        e = mq.pop_front();
                        chk("mem_kind", {31'd0, mem_write}, {31'd0, e.wr});
                        chk("mem_addr", {22'd0, mem_addr}, {22'd0, e.addr});
                        if (e.wr)
                            chk("mem_wdata", {22'd0, mem_wdata}, {22'd0, e.data});
                    end
                end
                if (cnt == MEM_WAIT + 1) begin
                    mem_ready = 1'b1;
                    if (mem_write)
                        ram[mem_addr] = mem_wdata;
                    else
                        mem_rdata = ram[mem_addr];
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Called at a negedge; drives one request, waits for completion, checks stall length.
    task automatic cpu_op(input logic rd, input logic wr, input logic [9:0] a,
                          input logic [9:0] d, input logic [9:0] exp, input int lat);
        int         low;
        logic [9:0] e;
        cpu_read  = rd;
        cpu_write = wr;
        cpu_addr  = a;
        cpu_wdata = d;
        if (rd && !wr)
            rdq.push_back(exp);
        low = 0;
        #1;
        while (!cache_Ready && low < 100) begin
            low++;
            @(negedge clk);
            #1;
        end
        chk("ready_seen", {31'd0, cache_Ready}, 1);
        chk("stall_cycles", low, lat);
        if (rd && !wr && rdq.size() > 0) begin
            e = rdq.pop_front();
            chk("cpu_rdata", {22'd0, cpu_rdata}, {22'd0, e});
        end
        @(negedge clk);
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
    endtask

    initial begin
        int waited;
        for (int i = 0; i < 1024; i++)
            ram[i] = 10'((i * 37 + 11) & 10'h3FF);
        ram[10'h005] = 10'h2AA;
        ram[10'h00D] = 10'h0F0;
        ram[10'h3F8] = 10'h111;
        ram[10'h000] = 10'h0A0;
        ram[10'h008] = 10'h0C8;
        ram[10'h021] = 10'h321;

        reset     = 1'b1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", {31'd0, cache_Ready}, 1);
        chk("rst_mem_read", {31'd0, mem_read}, 0);
        chk("rst_mem_write", {31'd0, mem_write}, 0);
        @(negedge clk);
        reset = 1'b0;

        // cold read, then immediate hit
        mq.push_back('{1'b0, 10'h005, 10'h000});
        cpu_op(1, 0, 10'h005, 10'h000, 10'h2AA, 5);
        cpu_op(1, 0, 10'h005, 10'h000, 10'h2AA, 0);

        // write hit, then conflicting read forces writeback of the dirty word
        cpu_op(0, 1, 10'h005, 10'h155, 10'h000, 0);
        mq.push_back('{1'b1, 10'h005, 10'h155});
        mq.push_back('{1'b0, 10'h00D, 10'h000});
        cpu_op(1, 0, 10'h00D, 10'h000, 10'h0F0, 9);
        chk("wb_ram_005", {22'd0, ram[10'h005]}, 10'h155);

        // write miss to an invalid line: allocate only, then the store lands dirty
        mq.push_back('{1'b0, 10'h3F8, 10'h000});
        cpu_op(0, 1, 10'h3F8, 10'h001, 10'h000, 5);
        cpu_op(1, 0, 10'h3F8, 10'h000, 10'h001, 0);
        mq.push_back('{1'b1, 10'h3F8, 10'h001});
        mq.push_back('{1'b0, 10'h000, 10'h000});
        cpu_op(1, 0, 10'h000, 10'h000, 10'h0A0, 9);
        chk("wb_ram_3f8", {22'd0, ram[10'h3F8]}, 10'h001);

        // read+write together on a hit acts as a store and marks the line dirty
        cpu_op(1, 1, 10'h000, 10'h2C3, 10'h000, 0);
        cpu_op(1, 0, 10'h000, 10'h000, 10'h2C3, 0);
        mq.push_back('{1'b1, 10'h000, 10'h2C3});
        mq.push_back('{1'b0, 10'h008, 10'h000});
        cpu_op(1, 0, 10'h008, 10'h000, 10'h0C8, 9);

        // dirty a line, then reset in the middle of an unrelated allocate
        cpu_op(0, 1, 10'h008, 10'h0AB, 10'h000, 0);
        mq.push_back('{1'b0, 10'h021, 10'h000});
        cpu_read = 1'b1;
        cpu_addr = 10'h021;
        waited   = 0;
        while (!mem_read && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("alloc_started", {31'd0, mem_read}, 1);
        reset    = 1'b1;
        cpu_read = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_abort_mem_read", {31'd0, mem_read}, 0);
        chk("rst_abort_ready", {31'd0, cache_Ready}, 1);
        @(negedge clk);
        reset = 1'b0;

        // previously dirty line is gone: clean allocate, no writeback
        mq.push_back('{1'b0, 10'h008, 10'h000});
        cpu_op(1, 0, 10'h008, 10'h000, 10'h0C8, 5);
        mq.push_back('{1'b0, 10'h021, 10'h000});
        cpu_op(1, 0, 10'h021, 10'h000, 10'h321, 5);
        chk("ram_008_untouched", {22'd0, ram[10'h008]}, 10'h0C8);

        repeat (3) @(negedge clk);
        chk("mem_queue_drained", mq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
